adc_spi_responder: RTL and testbench
====================================

# adc_spi_responder

Serial-register responder implementing the slave end of the ADS4128-style 3-wire control interface (SEN/SCLK/SDATA in, SDOUT out) inside the FPGA, clocked by `clk_usb`. It oversamples the pins, decodes 16-bit address/data frames into a local register file and serves readout frames on SDOUT. It is the loopback and self-test target for the bit-banged ADC control path, and the base for target-side emulation.

## Interface
- `pNUM_REGS`, 8: implemented registers at addresses 0..pNUM_REGS-1, legal range 1..256.
- `pSYNC_STAGES`, 2: flops per input synchronizer, minimum 2.
- `clk_usb`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `adc_reset`  in  1  pin-level hardware reset, active high, asynchronous to `clk_usb`.
- `adc_sen`  in  1  frame select, active low.
- `adc_sclk`  in  1  serial clock.
- `adc_sdata`  in  1  serial data in, MSB first.
- `adc_sdout`  out  1  serial data out, readout mode only.
- `cfg_addr`  in  8  local read address.
- `cfg_data`  out  8  combinational register read. Returns 0 for addresses ≥ pNUM_REGS.
- `frame_done`  out  1  one-cycle pulse when a frame completes.
- `frame_addr`  out  8  address of the last completed frame.
- `frame_data`  out  8  data of the last completed frame: the written byte, or the byte read out.
- `frame_err`  out  1  one-cycle pulse when a frame aborts.
- `err_count`  out  8  count of aborted frames.

## Operation
- `adc_sen`, `adc_sclk`, `adc_sdata` and `adc_reset` each pass through a pSYNC_STAGES synchronizer. Edge detection runs on the synchronized `adc_sclk`.
- SDATA is sampled on SCLK falling edges. SDOUT is updated on SCLK rising edges.
- States:
  - IDLE: synchronized SEN falling → ADDR, bit count cleared.
  - ADDR: 8 falling edges shift the address → DATA.
  - DATA: 8 falling edges shift the data. On the 8th edge the frame commits → DONE.
  - DONE: further SCLK edges are ignored and `adc_sdout` is held 0.
  - SEN rising returns to IDLE from any state.
- Commit: `frame_done` pulses and `frame_addr`/`frame_data` update.
  - Address < pNUM_REGS and permitted: the register is written.
  - Address ≥ pNUM_REGS: the write is dropped, and a readout returns 0x00.
- Register 0x00 bit0 is READOUT. Register 0x00 bit1 is SOFT_RESET, self-clearing: a commit with bit1=1 clears every register, including 0x00.
- READOUT=1:
  - Commits to addresses other than 0x00 do not write.
  - The addressed register is captured at the 8th address bit and driven MSB first: D7 on the 9th rising edge through D0 on the 16th.
  - `frame_data` reports the byte driven out.
- READOUT=0: `adc_sdout` is held 0.
- Abort: SEN rises in ADDR or DATA, i.e. fewer than 16 bits. Result: no write, `frame_err` pulses, and the counter increments.
- A synchronized `adc_reset` high clears all registers and forces IDLE. Any in-progress frame is discarded without `frame_err`.

## Timing
- Reset values:
  - `adc_sdout`, `frame_done`, `frame_err` = 0.
  - `frame_addr`, `frame_data`, `err_count` = 0x00.
  - All registers 0x00; state IDLE.
- Latency from a pin edge to the registered effect is pSYNC_STAGES+1 cycles, which gives an `adc_sdout` update 3 cycles after the SCLK rise at default settings.
- SCLK and SEN must each be stable for at least pSYNC_STAGES+2 cycles per level. Faster toggling is out of spec.
- Register write, `frame_done` and `frame_data` all occur in the same cycle as the 16th detected falling edge. `cfg_data` reflects the new value on the next cycle.
- SCLK edges while SEN is high are ignored.
- A SEN rise and an SCLK edge detected in the same cycle: the SEN rise takes priority and the edge is discarded.
- `reset_n` low mid-frame: all state returns to reset values immediately.

## Configuration
- `ADC_RESP_ERRCNT_EN`:
  - Defined: `err_count` is an 8-bit counter that saturates at 0xFF and is cleared only by `reset_n`.
  - Undefined: `err_count` is tied to 0x00 and the counter logic is absent. `frame_err` is present in both cases.

## Test plan
- Write frame A=0x05, D=0xAA, SCLK half-period 8 cycles → `frame_done` pulse, `frame_addr`=0x05, `frame_data`=0xAA; `cfg_addr`=0x05 → `cfg_data`=0xAA.
- Write 0x01 to 0x00, then a readout frame with A=0x05 → `adc_sdout` sequence 1,0,1,0,1,0,1,0 on rising edges 9–16, `frame_data`=0xAA.
- With READOUT=1, write D=0x33 to 0x05 → register stays 0xAA. Then write 0x00 to 0x00 → READOUT clears and `adc_sdout` stays 0.
- SEN rises after 10 bits → `frame_err` pulse, `err_count`=1 (0 without the macro), no register change. Frame to A=0x09 with pNUM_REGS=8 → no write, `frame_done` pulses.
- Write 0x02 to 0x00 → all registers read 0x00. Pulse `adc_reset` mid-frame → registers cleared, no `frame_err`, next frame decodes correctly.
- Assert `reset_n` low after 12 bits → all outputs at reset values; a subsequent full frame commits normally.

Source files
------------

// File: rtl/adc_spi_responder.sv
// rtl/adc_spi_responder.sv - 3-wire SEN/SCLK/SDATA register responder with SDOUT readout.
// Optional saturating abort counter enabled by ADC_RESP_ERRCNT_EN.
module adc_spi_responder #(
    parameter int pNUM_REGS    = 8,
    parameter int pSYNC_STAGES = 2
) (
    input  logic       clk_usb,
    input  logic       reset_n,
    input  logic       adc_reset,
    input  logic       adc_sen,
    input  logic       adc_sclk,
    input  logic       adc_sdata,
    output logic       adc_sdout,
    input  logic [7:0] cfg_addr,
    output logic [7:0] cfg_data,
    output logic       frame_done,
    output logic [7:0] frame_addr,
    output logic [7:0] frame_data,
    output logic       frame_err,
    output logic [7:0] err_count
);
    localparam int IDXW = (pNUM_REGS > 1) ? $clog2(pNUM_REGS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } state_t;

    logic [pSYNC_STAGES-1:0] sen_sync_q, sen_sync_d;
    logic [pSYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [pSYNC_STAGES-1:0] sdata_sync_q, sdata_sync_d;
    logic [pSYNC_STAGES-1:0] rst_sync_q, rst_sync_d;

    logic       sen_prev_q, sen_prev_d;
    logic       sclk_prev_q, sclk_prev_d;
    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] addr_sh_q, addr_sh_d;
    logic [7:0] data_sh_q, data_sh_d;
    logic [7:0] out_sh_q, out_sh_d;
    logic [7:0] rd_byte_q, rd_byte_d;
    logic       rd_mode_q, rd_mode_d;
    logic       sdout_q, sdout_d;
    logic       frame_done_q, frame_done_d;
    logic       frame_err_q, frame_err_d;
    logic [7:0] frame_addr_q, frame_addr_d;
    logic [7:0] frame_data_q, frame_data_d;
    logic [7:0] regs_q [pNUM_REGS];
    logic [7:0] regs_d [pNUM_REGS];

    logic       sen_s, sclk_s, sdata_s, rst_s;
    logic       sclk_rise, sclk_fall, sen_rise, sen_fall;
    logic [7:0] cap_addr, cap_byte, commit_data;
    logic       commit_in_range;

    assign sen_s   = sen_sync_q[pSYNC_STAGES-1];
    assign sclk_s  = sclk_sync_q[pSYNC_STAGES-1];
    assign sdata_s = sdata_sync_q[pSYNC_STAGES-1];
    assign rst_s   = rst_sync_q[pSYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign sen_rise  = sen_s & ~sen_prev_q;
    assign sen_fall  = ~sen_s & sen_prev_q;

    // Address as it will stand once the current falling edge is shifted in.
    assign cap_addr        = {addr_sh_q[6:0], sdata_s};
    assign cap_byte        = (int'(cap_addr) < pNUM_REGS) ? regs_q[cap_addr[IDXW-1:0]] : 8'h00;
    assign commit_data     = {data_sh_q[6:0], sdata_s};
    assign commit_in_range = int'(addr_sh_q) < pNUM_REGS;

    assign cfg_data = (int'(cfg_addr) < pNUM_REGS) ? regs_q[cfg_addr[IDXW-1:0]] : 8'h00;

    always_comb begin
        sen_sync_d   = {sen_sync_q[pSYNC_STAGES-2:0], adc_sen};
        sclk_sync_d  = {sclk_sync_q[pSYNC_STAGES-2:0], adc_sclk};
        sdata_sync_d = {sdata_sync_q[pSYNC_STAGES-2:0], adc_sdata};
        rst_sync_d   = {rst_sync_q[pSYNC_STAGES-2:0], adc_reset};
        sen_prev_d   = sen_s;
        sclk_prev_d  = sclk_s;

        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        addr_sh_d    = addr_sh_q;
        data_sh_d    = data_sh_q;
        out_sh_d     = out_sh_q;
        rd_byte_d    = rd_byte_q;
        rd_mode_d    = rd_mode_q;
        sdout_d      = sdout_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        frame_addr_d = frame_addr_q;
        frame_data_d = frame_data_q;
        regs_d       = regs_q;

        if (rst_s) begin
            // Pin-level reset silently discards any frame in flight.
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            sdout_d   = 1'b0;
            rd_mode_d = 1'b0;
            for (int i = 0; i < pNUM_REGS; i++) begin
                regs_d[i] = 8'h00;
            end
        end else if (sen_rise) begin
            if (state_q == ST_ADDR || state_q == ST_DATA) begin
                frame_err_d = 1'b1;
            end
            state_d = ST_IDLE;
            sdout_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sdout_d = 1'b0;
                    if (sen_fall) begin
                        state_d   = ST_ADDR;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_ADDR: begin
                    if (sclk_fall) begin
                        addr_sh_d = cap_addr;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d   = ST_DATA;
                            rd_mode_d = regs_q[0][0];
                            rd_byte_d = cap_byte;
                            out_sh_d  = cap_byte;
                        end
                    end
                end
                ST_DATA: begin
                    if (sclk_rise) begin
                        sdout_d  = rd_mode_q & out_sh_q[7];
                        out_sh_d = {out_sh_q[6:0], 1'b0};
                    end else if (sclk_fall) begin
                        data_sh_d = commit_data;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d      = ST_DONE;
                            sdout_d      = 1'b0;
                            frame_done_d = 1'b1;
                            frame_addr_d = addr_sh_q;
                            frame_data_d = rd_mode_q ? rd_byte_q : commit_data;
                            // In readout mode only register 0 stays writable so it can be turned off.
                            if (commit_in_range && (!regs_q[0][0] || addr_sh_q == 8'h00)) begin
                                if (addr_sh_q == 8'h00 && commit_data[1]) begin
                                    for (int i = 0; i < pNUM_REGS; i++) begin
                                        regs_d[i] = 8'h00;
                                    end
                                end else begin
                                    regs_d[addr_sh_q[IDXW-1:0]] = commit_data;
                                end
                            end
                        end
                    end
                end
                ST_DONE: begin
                    sdout_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            sen_sync_q   <= '1;
            sclk_sync_q  <= '0;
            sdata_sync_q <= '0;
            rst_sync_q   <= '0;
            sen_prev_q   <= 1'b1;
            sclk_prev_q  <= 1'b0;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            addr_sh_q    <= 8'h00;
            data_sh_q    <= 8'h00;
            out_sh_q     <= 8'h00;
            rd_byte_q    <= 8'h00;
            rd_mode_q    <= 1'b0;
            sdout_q      <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_addr_q <= 8'h00;
            frame_data_q <= 8'h00;
            for (int i = 0; i < pNUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            sen_sync_q   <= sen_sync_d;
            sclk_sync_q  <= sclk_sync_d;
            sdata_sync_q <= sdata_sync_d;
            rst_sync_q   <= rst_sync_d;
            sen_prev_q   <= sen_prev_d;
            sclk_prev_q  <= sclk_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            addr_sh_q    <= addr_sh_d;
            data_sh_q    <= data_sh_d;
            out_sh_q     <= out_sh_d;
            rd_byte_q    <= rd_byte_d;
            rd_mode_q    <= rd_mode_d;
            sdout_q      <= sdout_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            frame_addr_q <= frame_addr_d;
            frame_data_q <= frame_data_d;
            for (int i = 0; i < pNUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign adc_sdout  = sdout_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign frame_addr = frame_addr_q;
    assign frame_data = frame_data_q;

`ifdef ADC_RESP_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (frame_err_d && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q <= 8'h00;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb/tb_adc_spi_responder.sv - self-checking bench for adc_spi_responder.
// Frame-level reference model of the register file, readout and abort counter.
module tb_adc_spi_responder;
    logic       clk_usb = 1'b0;
    logic       reset_n;
    logic       adc_reset;
    logic       adc_sen;
    logic       adc_sclk;
    logic       adc_sdata;
    logic       adc_sdout;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       frame_done;
    logic [7:0] frame_addr;
    logic [7:0] frame_data;
    logic       frame_err;
    logic [7:0] err_count;

    always #5 clk_usb = ~clk_usb;

    adc_spi_responder #(.pNUM_REGS(8), .pSYNC_STAGES(2)) dut (
        .clk_usb   (clk_usb),
        .reset_n   (reset_n),
        .adc_reset (adc_reset),
        .adc_sen   (adc_sen),
        .adc_sclk  (adc_sclk),
        .adc_sdata (adc_sdata),
        .adc_sdout (adc_sdout),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .frame_done(frame_done),
        .frame_addr(frame_addr),
        .frame_data(frame_data),
        .frame_err (frame_err),
        .err_count (err_count)
    );

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int err_seen = 0;
    logic [7:0] m_regs [8];
    int m_errcnt = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp_fd;
        logic [7:0] exp_cfg;
    } vec_t;
    vec_t vecs [5];

    always @(negedge clk_usb) begin
        if (frame_done === 1'b1) done_seen++;
        if (frame_err === 1'b1) err_seen++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_usb);
    endtask

    function automatic int exp_errcount();
`ifdef ADC_RESP_ERRCNT_EN
        return m_errcnt;
`else
        return 0;
`endif
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    endtask

    // Drops SEN and clocks nbits bits; collects SDOUT seen after rising edges 9..16.
    task automatic shift_bits(input logic [7:0] a, input logic [7:0] d, input int nbits,
                              output logic [7:0] sdout_byte);
        logic [15:0] word;
        word = {a, d};
        sdout_byte = 8'h00;
        adc_sen = 1'b0;
        wait_cyc(8);
        for (int i = 0; i < nbits; i++) begin
            adc_sclk  = 1'b1;
            adc_sdata = word[15-i];
            wait_cyc(8);
            if (i >= 8) sdout_byte = {sdout_byte[6:0], adc_sdout};
            adc_sclk = 1'b0;
            wait_cyc(8);
        end
    endtask

    task automatic end_frame();
        adc_sen   = 1'b1;
        adc_sdata = 1'b0;
        wait_cyc(8);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 10; i++) begin
            cfg_addr = 8'(i);
            wait_cyc(1);
            chk($sformatf("%s_cfg%0d", tag, i), cfg_data, (i < 8) ? m_regs[i] : 8'h00);
        end
    endtask

    // Runs one frame and checks it against the register-file model.
    task automatic model_frame(input logic [7:0] a, input logic [7:0] d, input int nbits,
                               input string tag, output logic [7:0] got_out);
        int d0, e0;
        logic ro;
        logic [7:0] byte_at_a, exp_out;
        d0 = done_seen;
        e0 = err_seen;
        ro = m_regs[0][0];
        byte_at_a = (a < 8) ? m_regs[a[2:0]] : 8'h00;
        exp_out = ro ? byte_at_a : 8'h00;
        shift_bits(a, d, nbits, got_out);
        end_frame();
        if (nbits < 16) begin
            if (m_errcnt < 255) m_errcnt++;
            chk({tag, "_err_pulse"}, err_seen - e0, 1);
            chk({tag, "_no_done"}, done_seen - d0, 0);
        end else begin
            chk({tag, "_done_pulse"}, done_seen - d0, 1);
            chk({tag, "_no_err"}, err_seen - e0, 0);
            chk({tag, "_faddr"}, frame_addr, a);
            chk({tag, "_fdata"}, frame_data, ro ? byte_at_a : d);
            chk({tag, "_sdout"}, got_out, exp_out);
            if (a < 8 && (!ro || a == 8'h00)) begin
                if (a == 8'h00 && d[1]) model_clear();
                else m_regs[a[2:0]] = d;
            end
        end
        chk({tag, "_errcnt"}, err_count, exp_errcount());
    endtask

    initial begin
        logic [7:0] got;
        logic [7:0] ra, rd;
        int nb, d0, e0;

        vecs[0] = '{8'h05, 8'hAA, 8'hAA, 8'hAA};
        vecs[1] = '{8'h07, 8'h3C, 8'h3C, 8'h3C};
        vecs[2] = '{8'h09, 8'h55, 8'h55, 8'h00};
        vecs[3] = '{8'h01, 8'hFF, 8'hFF, 8'hFF};
        vecs[4] = '{8'h03, 8'h81, 8'h81, 8'h81};

        reset_n = 1'b0; adc_reset = 1'b0; adc_sen = 1'b1; adc_sclk = 1'b0;
        adc_sdata = 1'b0; cfg_addr = 8'h00;
        model_clear();
        wait_cyc(3);
        chk("rst_sdout", adc_sdout, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_faddr", frame_addr, 0);
        chk("rst_fdata", frame_data, 0);
        chk("rst_errcnt", err_count, 0);
        reset_n = 1'b1;
        wait_cyc(5);
        check_regs("rst");

        for (int v = 0; v < 5; v++) begin
            d0 = done_seen;
            shift_bits(vecs[v].a, vecs[v].d, 16, got);
            end_frame();
            chk($sformatf("vec%0d_done", v), done_seen - d0, 1);
            chk($sformatf("vec%0d_faddr", v), frame_addr, vecs[v].a);
            chk($sformatf("vec%0d_fdata", v), frame_data, vecs[v].exp_fd);
            chk($sformatf("vec%0d_sdout", v), got, 8'h00);
            cfg_addr = vecs[v].a;
            wait_cyc(1);
            chk($sformatf("vec%0d_cfg", v), cfg_data, vecs[v].exp_cfg);
            if (vecs[v].a < 8) m_regs[vecs[v].a[2:0]] = vecs[v].d;
        end

        // Readout of 0x05 after READOUT is set.
        model_frame(8'h00, 8'h01, 16, "ro_on", got);
        model_frame(8'h05, 8'h00, 16, "ro_rd", got);
        chk("ro_rd_sdout_aa", got, 8'hAA);
        chk("ro_rd_fdata_aa", frame_data, 8'hAA);
        model_frame(8'h05, 8'h33, 16, "ro_blk", got);
        cfg_addr = 8'h05;
        wait_cyc(1);
        chk("ro_blk_reg5", cfg_data, 8'hAA);
        model_frame(8'h00, 8'h00, 16, "ro_off", got);
        model_frame(8'h05, 8'h00, 16, "ro_off_rd", got);
        chk("ro_off_sdout_zero", got, 8'h00);

        // Abort after 10 bits, then an out-of-range frame.
        model_frame(8'h02, 8'h77, 10, "abort10", got);
        chk("abort10_count", err_count, exp_errcount());
        check_regs("abort10");
        model_frame(8'h09, 8'h12, 16, "oor", got);

        // Soft reset via register 0 bit1.
        model_frame(8'h04, 8'h5A, 16, "pre_soft", got);
        model_frame(8'h00, 8'h02, 16, "soft", got);
        check_regs("soft");

        // Pin-level reset mid-frame.
        model_frame(8'h06, 8'hC3, 16, "pre_pin", got);
        d0 = done_seen;
        e0 = err_seen;
        shift_bits(8'h06, 8'h11, 6, got);
        adc_reset = 1'b1;
        wait_cyc(6);
        adc_reset = 1'b0;
        wait_cyc(8);
        end_frame();
        chk("pin_no_err", err_seen - e0, 0);
        chk("pin_no_done", done_seen - d0, 0);
        model_clear();
        check_regs("pin");
        model_frame(8'h06, 8'h96, 16, "post_pin", got);

        // reset_n mid-frame after 12 bits.
        shift_bits(8'h06, 8'h0F, 12, got);
        cfg_addr = 8'h06;
        reset_n = 1'b0;
        #1;
        chk("rn_sdout", adc_sdout, 0);
        chk("rn_done", frame_done, 0);
        chk("rn_err", frame_err, 0);
        chk("rn_faddr", frame_addr, 0);
        chk("rn_fdata", frame_data, 0);
        chk("rn_errcnt", err_count, 0);
        chk("rn_cfg6", cfg_data, 0);
        adc_sen = 1'b1;
        adc_sclk = 1'b0;
        wait_cyc(8);
        reset_n = 1'b1;
        wait_cyc(8);
        model_clear();
        m_errcnt = 0;
        model_frame(8'h03, 8'hE7, 16, "post_rn", got);
        check_regs("post_rn");

        // Randomized frames against the model.
        for (int n = 0; n < 40; n++) begin
            ra = 8'($urandom_range(0, 11));
            rd = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                ra = 8'h00;
                rd = 8'($urandom_range(0, 3));
            end
            nb = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : 16;
            model_frame(ra, rd, nb, $sformatf("rnd%0d", n), got);
            if (n % 10 == 9) check_regs($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
